// File: rtl/aes_pkg.sv
// Shared AES types, round constants and GF(2^8) helpers.
// Optional feature macro: AES_KEY_REUSE_EN (see aes_key_expand).
package aes_pkg;

    localparam int AES_NR = 10;

    typedef logic [31:0]  aes_word_t;
    typedef logic [127:0] aes_block_t;

    typedef enum logic {
        IDLE,
        EXPAND
    } kexp_state_e;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Shift-and-add multiply, reducing by x^8+x^4+x^3+x+1 as we go
    function automatic logic [7:0] gf_mul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: GF(2^8) inverse (x^254) plus affine map.
// Shared by the key schedule and the cipher datapath.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    logic [7:0] x2;
    logic [7:0] x3;
    logic [7:0] x6;
    logic [7:0] x12;
    logic [7:0] x15;
    logic [7:0] x30;
    logic [7:0] x60;
    logic [7:0] x120;
    logic [7:0] x240;
    logic [7:0] x252;
    logic [7:0] inv;

    // Addition chain to x^254, which is the inverse (and maps 0 to 0)
    always_comb begin
        x2   = gf_mul(in_byte, in_byte);
        x3   = gf_mul(x2, in_byte);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        inv  = gf_mul(x252, x2);
    end

    assign out_byte = inv
                    ^ {inv[6:0], inv[7]}
                    ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]}
                    ^ 8'h63;

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry bank.
// Define AES_KEY_REUSE_EN to skip re-expansion when the same key is restarted.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
    output logic         valid,
    input  logic [3:0]   rk_addr,
    output logic [127:0] rk_data
);

    localparam logic [3:0] LAST = 4'(NR);

    kexp_state_e state_q, state_d;
    logic [3:0]  rnd_q, rnd_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        valid_q, valid_d;
    logic        hit_q, hit_d;
    logic        reuse_hit;

    aes_block_t  rk_q [0:NR];
    logic        wr_en;
    logic [3:0]  wr_idx;
    aes_block_t  wr_data;

    aes_block_t  prev;
    aes_word_t   rot;
    aes_word_t   sub;
    aes_word_t   t;
    aes_word_t   w0;
    aes_word_t   w1;
    aes_word_t   w2;
    aes_word_t   w3;
    aes_block_t  next_rk;

`ifdef AES_KEY_REUSE_EN
    aes_block_t  key_q, key_d;

    assign reuse_hit = valid_q && (key == key_q);
`else
    assign reuse_hit = 1'b0;
`endif

    assign prev = rk_q[rnd_q - 4'd1];
    assign rot  = {prev[23:0], prev[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sub
        aes_sbox u_sbox (
            .in_byte  (rot[8*g +: 8]),
            .out_byte (sub[8*g +: 8])
        );
    end

    assign t       = sub ^ {RCON[rnd_q], 24'h0};
    assign w0      = prev[127:96] ^ t;
    assign w1      = prev[95:64] ^ w0;
    assign w2      = prev[63:32] ^ w1;
    assign w3      = prev[31:0] ^ w2;
    assign next_rk = {w0, w1, w2, w3};

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        done_d  = hit_q;
        hit_d   = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = rnd_q;
        wr_data = next_rk;
`ifdef AES_KEY_REUSE_EN
        key_d   = key_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start && reuse_hit) begin
                    hit_d = 1'b1;
                end else if (start) begin
                    state_d = EXPAND;
                    rnd_d   = 4'd1;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                    wr_en   = 1'b1;
                    wr_idx  = 4'd0;
                    wr_data = key;
`ifdef AES_KEY_REUSE_EN
                    key_d   = key;
`endif
                end
            end
            EXPAND: begin
                wr_en = 1'b1;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == LAST) begin
                    state_d = IDLE;
                    rnd_d   = 4'd0;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            hit_q   <= hit_d;
        end
    end

`ifdef AES_KEY_REUSE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) key_q <= '0;
        else        key_q <= key_d;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
        end else if (wr_en) begin
            rk_q[wr_idx] <= wr_data;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign valid   = valid_q;
    assign rk_data = (rk_addr <= LAST) ? rk_q[rk_addr] : '0;

endmodule

// File: tb/tb_aes_key_expand.sv
// Randomized check of aes_key_expand against a FIPS-197 style key schedule model.
// Honours AES_KEY_REUSE_EN when it is defined for the whole build.
module tb_aes_key_expand;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key;
    logic         busy;
    logic         done;
    logic         valid;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;

    int total = 0;
    int bad   = 0;

    logic [7:0]   sb [256];
    logic [127:0] exp_rk [0:10];

    localparam logic [127:0] FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    aes_key_expand dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .key     (key),
        .busy    (busy),
        .done    (done),
        .valid   (valid),
        .rk_addr (rk_addr),
        .rk_data (rk_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Polynomial product then reduction modulo 0x11b
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
        return (v << k) | (v >> (8 - k));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                  ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r <= 10; r++)
            exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic read_rk(input int a, output logic [127:0] d);
        rk_addr = 4'(a);
        #1;
        d = rk_data;
    endtask

    task automatic start_key(input logic [127:0] k, output logic b0);
        @(negedge clk);
        start = 1'b1;
        key   = k;
        @(posedge clk);
        #1;
        start = 1'b0;
        key   = rnd128();
        b0    = busy;
    endtask

    // Bounded wait for done; lat=-1 on timeout; counts busy samples before done
    task automatic wait_done(output int lat, output int busy_n);
        lat    = -1;
        busy_n = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
            if (busy) busy_n++;
        end
    endtask

    task automatic check_bank(input string tag, input logic [127:0] k);
        logic [127:0] d;
        model(k);
        for (int i = 0; i <= 10; i++) begin
            read_rk(i, d);
            chk($sformatf("%s_rk%0d", tag, i), d, exp_rk[i]);
        end
    endtask

    task automatic full_run(input string tag, input logic [127:0] k);
        logic b0;
        int   lat;
        int   bn;
        start_key(k, b0);
        chk({tag, "_busy0"}, 128'(b0), 128'(1));
        wait_done(lat, bn);
        chk({tag, "_lat"}, 128'(lat), 128'(10));
        chk({tag, "_busyn"}, 128'(bn), 128'(9));
        chk({tag, "_st"}, {busy, valid}, {1'b0, 1'b1});
        check_bank(tag, k);
    endtask

    initial begin
        logic [127:0] d;
        logic [127:0] k;
        logic         b0;
        int           lat;
        int           bn;
        int           dn;

        rst_n   = 1'b0;
        start   = 1'b0;
        key     = '0;
        rk_addr = '0;
        build_sbox();
        #23;
        chk("rst_outs", {busy, done, valid}, 3'b000);
        read_rk(0, d);
        chk("rst_rk0", d, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero key straight after reset must expand fully
        full_run("zero", '0);
        read_rk(1, d);
        chk("zero_rk1_vec", d, 128'h62636363626363636263636362636363);
        read_rk(10, d);
        chk("zero_rk10_vec", d, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        for (int a = 11; a < 16; a++) begin
            read_rk(a, d);
            chk($sformatf("oob%0d", a), d, '0);
        end

        full_run("fips", FIPS);
        read_rk(1, d);
        chk("fips_rk1_vec", d, 128'ha0fafe1788542cb123a339392a6c7605);
        read_rk(10, d);
        chk("fips_rk10_vec", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        @(posedge clk);
        #1;
        chk("fips_done_fall", 128'(done), 128'(0));

        // Start pulse mid-expansion is ignored
        k = rnd128();
        start_key(k, b0);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        key   = rnd128();
        @(posedge clk);
        #1;
        start = 1'b0;
        dn = 0;
        for (int n = 0; n < 14; n++) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        chk("busy_ign_dones", 128'(dn), 128'(1));
        check_bank("busy_ign", k);

        // Reset in the middle of an expansion
        start_key(rnd128(), b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        read_rk(0, d);
        chk("midrst_outs", {busy, done, valid}, 3'b000);
        chk("midrst_rk0", d, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk);
            #1;
            if (done || busy) dn++;
        end
        chk("midrst_quiet", 128'(dn), 128'(0));
        full_run("post_rst", rnd128());

        // start held through completion: ignored at E10, accepted at E11
        k = rnd128();
        @(negedge clk);
        start = 1'b1;
        key   = k;
        @(posedge clk);
        #1;
        wait_done(lat, bn);
        chk("b2b_lat1", 128'(lat), 128'(10));
        k   = rnd128();
        key = k;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_restart", {busy, valid, done}, 3'b100);
        wait_done(lat, bn);
        chk("b2b_lat2", 128'(lat), 128'(10));
        check_bank("b2b", k);

        for (int i = 0; i < 5; i++)
            full_run($sformatf("rnd%0d", i), rnd128());

        // Restart with the key already in the bank
        k = rnd128();
        full_run("reuse_base", k);
        start_key(k, b0);
        wait_done(lat, bn);
`ifdef AES_KEY_REUSE_EN
        chk("reuse_lat", 128'(lat), 128'(1));
        chk("reuse_busy", {b0, 5'(bn)}, '0);
        chk("reuse_valid", 128'(valid), 128'(1));
`else
        chk("reuse_lat", 128'(lat), 128'(10));
        chk("reuse_busy", 128'(b0), 128'(1));
`endif
        check_bank("reuse", k);
        full_run("reuse_new", rnd128());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
